// File: rtl/mem_stage_pkg.sv
// Shared encodings and stage bundles for the memory pipeline stage.
// The pipeline fields are grouped into structs so hold and writeback registers move as one unit.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_LD   = 2'b01,
    MEM_ST   = 2'b10
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    TRD_NONE  = 2'b00,
    TRD_KILL  = 2'b01,
    TRD_SLEEP = 2'b10,
    TRD_WAKE  = 2'b11
  } trd_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Everything the stage needs from execute. Only the word address is kept.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  reg_wr;
    logic        wr_en;
    logic        wb_sel;
    logic [1:0]  mem_ctrl;
    logic [1:0]  trd_ctrl;
  } stage_t;

  // Everything writeback sees.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] data;
    logic [4:0]  reg_wr;
    logic        wr_en;
  } wb_t;

  function automatic logic is_load(input logic [1:0] ctrl);
    return ctrl == MEM_LD;
  endfunction

  function automatic logic is_store(input logic [1:0] ctrl);
    return ctrl == MEM_ST;
  endfunction

  // The encoding 2'b11 is illegal and behaves as no access.
  function automatic logic is_access(input logic [1:0] ctrl);
    return is_load(ctrl) || is_store(ctrl);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_if_fsm.sv
// Data-memory handshake: IDLE/BUSY state machine, hold registers and timeout counter.
// Decides when the instruction in the stage retires and resolves its writeback value.
module dmem_if_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TRD_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  stage_t           stage_i,
  input  logic [TRD_W-1:0] trd_i,
  input  logic [TRD_W-1:0] obj_trd_i,
  input  logic             misalign_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [31:0]      dmem_addr_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic             dmem_ack_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             stall_o,
  output logic             retire_o,
  output logic             abort_o,
  output wb_t              ret_o,
  output logic [1:0]       ret_trd_ctrl_o,
  output logic [TRD_W-1:0] ret_trd_o,
  output logic [TRD_W-1:0] ret_obj_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e       state_q, state_d;
  stage_t           hold_q, hold_d;
  logic [TRD_W-1:0] hold_trd_q, hold_trd_d;
  logic [TRD_W-1:0] hold_obj_q, hold_obj_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  stage_t           cur;
  logic [TRD_W-1:0] cur_trd, cur_obj;
  logic             req, stall, retire, abort;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_trd_d = hold_trd_q;
    hold_obj_d = hold_obj_q;
    cnt_d      = '0;
    cur        = stage_i;
    cur_trd    = trd_i;
    cur_obj    = obj_trd_i;
    req        = 1'b0;
    stall      = 1'b0;
    retire     = 1'b0;
    abort      = 1'b0;

    if (state_q == ST_BUSY) begin
      // A started access always finishes; flush is not looked at here.
      cur     = hold_q;
      cur_trd = hold_trd_q;
      cur_obj = hold_obj_q;
      req     = 1'b1;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      if (dmem_ack_i) begin
        retire  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        retire  = 1'b1;
        abort   = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        stall = 1'b1;
      end
    end else if (!flush_i) begin
      retire = 1'b1;
      if (is_access(stage_i.mem_ctrl)) begin
        if (misalign_i) begin
          abort = 1'b1;
        end else begin
          req = 1'b1;
          if (!dmem_ack_i) begin
            retire     = 1'b0;
            stall      = 1'b1;
            state_d    = ST_BUSY;
            hold_d     = stage_i;
            hold_trd_d = trd_i;
            hold_obj_d = obj_trd_i;
          end
        end
      end
    end
  end

  always_comb begin
    ret_o        = '0;
    ret_o.pc     = cur.pc;
    ret_o.ins    = cur.ins;
    ret_o.reg_wr = cur.reg_wr;
    if (abort) begin
      ret_o.data  = '0;
      ret_o.wr_en = 1'b0;
    end else if (is_load(cur.mem_ctrl)) begin
      ret_o.data  = dmem_rdata_i;
      ret_o.wr_en = cur.wr_en;
    end else if (is_store(cur.mem_ctrl)) begin
      ret_o.data  = cur.data;
      ret_o.wr_en = 1'b0;
    end else begin
      ret_o.data  = cur.data;
      ret_o.wr_en = cur.wr_en & ~cur.wb_sel;
    end
  end

  // Reset is folded into the combinational outputs so an abandoned request drops at once.
  assign dmem_req_o     = req & ~rst;
  assign stall_o        = stall & ~rst;
  assign dmem_we_o      = dmem_req_o & is_store(cur.mem_ctrl);
  assign dmem_addr_o    = dmem_req_o ? {cur.waddr, 2'b00} : '0;
  assign dmem_wdata_o   = dmem_req_o ? cur.data : '0;
  assign retire_o       = retire;
  assign abort_o        = abort;
  assign ret_trd_ctrl_o = cur.trd_ctrl;
  assign ret_trd_o      = cur_trd;
  assign ret_obj_o      = cur_obj;

  // NOTE: state uses non-blocking assignments only; the hold registers are plain flops and
  // are reset along with everything else so no stale request fields survive a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_trd_q <= '0;
      hold_obj_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_trd_q <= hold_trd_d;
      hold_obj_q <= hold_obj_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-memory access, thread commands and the *_wb registers.
// Build option MEM_ALIGN_CHECK_EN rejects misaligned accesses instead of truncating the address.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TRD_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr_mem,
  input  logic [31:0]      ins_mem,
  input  logic [31:0]      pc_mem,
  input  logic [31:0]      exe_data_mem,
  input  logic [TRD_W-1:0] trd_mem,
  input  logic [4:0]       reg_wr_mem,
  input  logic             wr_en_mem,
  input  logic             wb_sel_mem,
  input  logic [1:0]       mem_ctrl_mem,
  input  logic [1:0]       trd_ctrl_mem,
  input  logic [TRD_W-1:0] obj_trd_mem,
  input  logic             flushMEM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             trd_cmd_en,
  output logic [1:0]       trd_cmd,
  output logic [TRD_W-1:0] trd_cmd_id,
  output logic             stall_mem,
  output logic             mem_err,
  output logic [31:0]      pc_wb,
  output logic [31:0]      ins_wb,
  output logic [TRD_W-1:0] trd_wb,
  output logic [4:0]       reg_wr_wb,
  output logic [31:0]      wb_data_wb,
  output logic             wr_en_wb
);

  stage_t           stage;
  logic             misalign;
  logic             retire, abort;
  wb_t              ret;
  logic [1:0]       ret_trd_ctrl;
  logic [TRD_W-1:0] ret_trd, ret_obj;

  assign stage = '{
    waddr:    addr_mem[31:2],
    ins:      ins_mem,
    pc:       pc_mem,
    data:     exe_data_mem,
    reg_wr:   reg_wr_mem,
    wr_en:    wr_en_mem,
    wb_sel:   wb_sel_mem,
    mem_ctrl: mem_ctrl_mem,
    trd_ctrl: trd_ctrl_mem
  };

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (addr_mem[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  dmem_if_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TRD_W      (TRD_W)
  ) u_dmem_if (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flushMEM),
    .stage_i       (stage),
    .trd_i         (trd_mem),
    .obj_trd_i     (obj_trd_mem),
    .misalign_i    (misalign),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_ack_i    (dmem_ack),
    .dmem_rdata_i  (dmem_rdata),
    .stall_o       (stall_mem),
    .retire_o      (retire),
    .abort_o       (abort),
    .ret_o         (ret),
    .ret_trd_ctrl_o(ret_trd_ctrl),
    .ret_trd_o     (ret_trd),
    .ret_obj_o     (ret_obj)
  );

  wb_t              wb_q, wb_d;
  logic [TRD_W-1:0] trd_wb_q, trd_wb_d;
  logic             cmd_en_q, cmd_en_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [TRD_W-1:0] cmd_id_q, cmd_id_d;
  logic             err_q, err_d;

  // Anything that does not retire this cycle (stall, flush) leaves a zero bubble in WB.
  // The thread command fires only on retirement, so a stalled instruction pulses once.
  always_comb begin
    wb_d     = '0;
    trd_wb_d = '0;
    cmd_en_d = 1'b0;
    cmd_d    = TRD_NONE;
    cmd_id_d = '0;
    err_d    = abort;
    if (retire) begin
      wb_d     = ret;
      trd_wb_d = ret_trd;
      if (ret_trd_ctrl != TRD_NONE) begin
        cmd_en_d = 1'b1;
        cmd_d    = ret_trd_ctrl;
        cmd_id_d = ret_obj;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= '0;
      trd_wb_q <= '0;
      cmd_en_q <= 1'b0;
      cmd_q    <= TRD_NONE;
      cmd_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      trd_wb_q <= trd_wb_d;
      cmd_en_q <= cmd_en_d;
      cmd_q    <= cmd_d;
      cmd_id_q <= cmd_id_d;
      err_q    <= err_d;
    end
  end

  assign pc_wb      = wb_q.pc;
  assign ins_wb     = wb_q.ins;
  assign wb_data_wb = wb_q.data;
  assign reg_wr_wb  = wb_q.reg_wr;
  assign wr_en_wb   = wb_q.wr_en;
  assign trd_wb     = trd_wb_q;
  assign trd_cmd_en = cmd_en_q;
  assign trd_cmd    = cmd_q;
  assign trd_cmd_id = cmd_id_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT_CYC = 4: pass-through, loads, stores,
// timeout, thread commands, flush and asynchronous reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_mem, ins_mem, pc_mem, exe_data_mem;
  logic [2:0]  trd_mem, obj_trd_mem;
  logic [4:0]  reg_wr_mem;
  logic        wr_en_mem, wb_sel_mem, flushMEM;
  logic [1:0]  mem_ctrl_mem, trd_ctrl_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        trd_cmd_en, stall_mem, mem_err, wr_en_wb;
  logic [1:0]  trd_cmd;
  logic [2:0]  trd_cmd_id, trd_wb;
  logic [31:0] pc_wb, ins_wb, wb_data_wb;
  logic [4:0]  reg_wr_wb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(4), .TRD_W(3)) dut (
    .clk(clk), .rst(rst),
    .addr_mem(addr_mem), .ins_mem(ins_mem), .pc_mem(pc_mem), .exe_data_mem(exe_data_mem),
    .trd_mem(trd_mem), .reg_wr_mem(reg_wr_mem), .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem),
    .mem_ctrl_mem(mem_ctrl_mem), .trd_ctrl_mem(trd_ctrl_mem), .obj_trd_mem(obj_trd_mem),
    .flushMEM(flushMEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .trd_cmd_en(trd_cmd_en), .trd_cmd(trd_cmd), .trd_cmd_id(trd_cmd_id),
    .stall_mem(stall_mem), .mem_err(mem_err),
    .pc_wb(pc_wb), .ins_wb(ins_wb), .trd_wb(trd_wb), .reg_wr_wb(reg_wr_wb),
    .wb_data_wb(wb_data_wb), .wr_en_wb(wr_en_wb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream bubble: all stage inputs zero.
  task automatic bubble();
    addr_mem = '0; ins_mem = '0; pc_mem = '0; exe_data_mem = '0;
    trd_mem = '0; obj_trd_mem = '0; reg_wr_mem = '0;
    wr_en_mem = 1'b0; wb_sel_mem = 1'b0; flushMEM = 1'b0;
    mem_ctrl_mem = 2'b00; trd_ctrl_mem = 2'b00;
  endtask

  // Land 1 time unit after the rising edge: registered outputs are settled there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #22;
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_mem, 0);
    check("rst_wr_en_wb", wr_en_wb, 0);
    check("rst_wb_data", wb_data_wb, 0);
    check("rst_pc_wb", pc_wb, 0);
    check("rst_trd_cmd_en", trd_cmd_en, 0);
    check("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    cyc();

    // ALU pass-through
    exe_data_mem = 32'h1234; wr_en_mem = 1'b1; reg_wr_mem = 5'd5; pc_mem = 32'h1000; ins_mem = 32'h13;
    #1;
    check("pt_req", dmem_req, 0);
    check("pt_stall", stall_mem, 0);
    cyc();
    check("pt_wb_data", wb_data_wb, 32'h1234);
    check("pt_wr_en_wb", wr_en_wb, 1);
    check("pt_reg_wr_wb", reg_wr_wb, 5);
    check("pt_pc_wb", pc_wb, 32'h1000);
    check("pt_ins_wb", ins_wb, 32'h13);

    // Illegal mem_ctrl 11 behaves as none; wb_sel masks the write enable
    bubble();
    mem_ctrl_mem = 2'b11; addr_mem = 32'h300; exe_data_mem = 32'h77; wr_en_mem = 1'b1; wb_sel_mem = 1'b1;
    reg_wr_mem = 5'd6;
    #1;
    check("ill_req", dmem_req, 0);
    check("ill_stall", stall_mem, 0);
    cyc();
    check("ill_wb_data", wb_data_wb, 32'h77);
    check("ill_wr_en_wb", wr_en_wb, 0);

    // Stray ack with no request is ignored
    bubble();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF; exe_data_mem = 32'h99; wr_en_mem = 1'b1; reg_wr_mem = 5'd8;
    cyc();
    dmem_ack = 1'b0;
    check("stray_wb_data", wb_data_wb, 32'h99);
    check("stray_wr_en_wb", wr_en_wb, 1);

    // Load with ack in the fourth cycle: three stall cycles
    bubble();
    mem_ctrl_mem = 2'b01; addr_mem = 32'h100; wr_en_mem = 1'b1; wb_sel_mem = 1'b1;
    reg_wr_mem = 5'd7; pc_mem = 32'h2000;
    #1;
    check("ld_req0", dmem_req, 1);
    check("ld_we0", dmem_we, 0);
    check("ld_addr0", dmem_addr, 32'h100);
    check("ld_stall0", stall_mem, 1);
    cyc();
    bubble();
    check("ld_bubble1", wr_en_wb, 0);
    #1;
    check("ld_req1", dmem_req, 1);
    check("ld_addr1", dmem_addr, 32'h100);
    check("ld_stall1", stall_mem, 1);
    cyc();
    check("ld_bubble2", wr_en_wb, 0);
    #1;
    check("ld_addr2", dmem_addr, 32'h100);
    check("ld_stall2", stall_mem, 1);
    cyc();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld_req3", dmem_req, 1);
    check("ld_stall3", stall_mem, 0);
    cyc();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("ld_wb_data", wb_data_wb, 32'hDEADBEEF);
    check("ld_wr_en_wb", wr_en_wb, 1);
    check("ld_reg_wr_wb", reg_wr_wb, 7);
    check("ld_pc_wb", pc_wb, 32'h2000);
    #1;
    check("ld_req_done", dmem_req, 0);

    // Store with zero-wait ack
    bubble();
    mem_ctrl_mem = 2'b10; addr_mem = 32'h204; exe_data_mem = 32'hA5A5; wr_en_mem = 1'b1; reg_wr_mem = 5'd9;
    dmem_ack = 1'b1;
    #1;
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_addr", dmem_addr, 32'h204);
    check("st_wdata", dmem_wdata, 32'hA5A5);
    check("st_stall", stall_mem, 0);
    cyc();
    dmem_ack = 1'b0;
    bubble();
    check("st_wr_en_wb", wr_en_wb, 0);
    #1;
    check("st_we_after", dmem_we, 0);
    check("st_req_after", dmem_req, 0);

    // Load with no ack: four BUSY cycles with req, then abort
    bubble();
    mem_ctrl_mem = 2'b01; addr_mem = 32'h40; wr_en_mem = 1'b1; reg_wr_mem = 5'd10;
    #1;
    check("to_stall_entry", stall_mem, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bubble();
      #1;
      check("to_req", dmem_req, 1);
      check("to_stall", stall_mem, (i < 3) ? 32'd1 : 32'd0);
      check("to_err_early", mem_err, 0);
    end
    cyc();
    check("to_mem_err", mem_err, 1);
    check("to_wr_en_wb", wr_en_wb, 0);
    check("to_req_drop", dmem_req, 0);
    check("to_stall_drop", stall_mem, 0);
    cyc();
    check("to_err_pulse", mem_err, 0);

    // Kill issued by a stalled load, with a flush ignored while BUSY
    bubble();
    mem_ctrl_mem = 2'b01; addr_mem = 32'h180; trd_ctrl_mem = 2'b01; obj_trd_mem = 3'd3; trd_mem = 3'd2;
    wr_en_mem = 1'b1; reg_wr_mem = 5'd11;
    #1;
    check("kill_stall0", stall_mem, 1);
    cyc();
    bubble();
    flushMEM = 1'b1;
    check("kill_en0", trd_cmd_en, 0);
    #1;
    check("kill_stall1", stall_mem, 1);
    check("kill_req1", dmem_req, 1);
    cyc();
    flushMEM = 1'b0;
    check("kill_en1", trd_cmd_en, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA;
    #1;
    check("kill_stall2", stall_mem, 0);
    cyc();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("kill_en2", trd_cmd_en, 1);
    check("kill_cmd", trd_cmd, 2'b01);
    check("kill_id", trd_cmd_id, 3);
    check("kill_wb_data", wb_data_wb, 32'h55AA);
    check("kill_trd_wb", trd_wb, 2);
    check("kill_wr_en_wb", wr_en_wb, 1);
    cyc();
    check("kill_en3", trd_cmd_en, 0);

    // Flush in IDLE: no access, no command, bubble in WB
    bubble();
    mem_ctrl_mem = 2'b01; addr_mem = 32'h1C0; trd_ctrl_mem = 2'b10; obj_trd_mem = 3'd5;
    wr_en_mem = 1'b1; exe_data_mem = 32'h55; flushMEM = 1'b1;
    #1;
    check("fl_req", dmem_req, 0);
    check("fl_stall", stall_mem, 0);
    cyc();
    bubble();
    check("fl_wr_en_wb", wr_en_wb, 0);
    check("fl_wb_data", wb_data_wb, 0);
    check("fl_cmd_en", trd_cmd_en, 0);

    // Asynchronous reset while BUSY, then a normal load
    mem_ctrl_mem = 2'b01; addr_mem = 32'h80; wr_en_mem = 1'b1; reg_wr_mem = 5'd12;
    #1;
    check("ar_req0", dmem_req, 1);
    cyc();
    bubble();
    #1;
    check("ar_req1", dmem_req, 1);
    check("ar_stall1", stall_mem, 1);
    rst = 1'b1;
    #1;
    check("ar_req_rst", dmem_req, 0);
    check("ar_stall_rst", stall_mem, 0);
    #1;
    rst = 1'b0;
    cyc();
    mem_ctrl_mem = 2'b01; addr_mem = 32'h84; wr_en_mem = 1'b1; reg_wr_mem = 5'd13;
    #1;
    check("ar2_req", dmem_req, 1);
    check("ar2_addr", dmem_addr, 32'h84);
    cyc();
    bubble();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
    #1;
    check("ar2_stall", stall_mem, 0);
    cyc();
    dmem_ack = 1'b0;
    check("ar2_wb_data", wb_data_wb, 32'hCAFE0001);
    check("ar2_wr_en_wb", wr_en_wb, 1);
    check("ar2_reg_wr_wb", reg_wr_wb, 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipeline; sits directly downstream of the execute stage and consumes its `*_mem` pipeline registers.
- Performs word loads/stores to data memory over a req/ack handshake with variable latency, and stalls the pipeline while an access is outstanding.
- Issues thread-control commands, and registers results into the `*_wb` pipeline registers that feed writeback and forwarding.

Parameters:
- TIMEOUT_CYC, 255: max cycles waiting for dmem_ack before aborting the access.
- TRD_W, 3: thread ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- addr_mem  in  32  byte address from execute
- ins_mem  in  32  instruction
- pc_mem  in  32  instruction PC
- exe_data_mem  in  32  execute result, or store data when store
- trd_mem  in  3  issuing thread
- reg_wr_mem  in  5  destination register
- wr_en_mem  in  1  register write enable
- wb_sel_mem  in  1  1 = writeback value comes from load
- mem_ctrl_mem  in  2  [1] store, [0] load; 00 none; 11 illegal (treated as none)
- trd_ctrl_mem  in  2  00 none, 01 kill, 10 sleep, 11 wake
- obj_trd_mem  in  3  target thread of trd_ctrl
- flushMEM  in  1  discard the current stage contents
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete
- dmem_rdata  in  32  load data, valid with ack
- trd_cmd_en  out  1  one-cycle pulse to thread scheduler
- trd_cmd  out  2  command
- trd_cmd_id  out  3  target thread
- stall_mem  out  1  pipeline hold request
- mem_err  out  1  one-cycle pulse on timeout (or misalign, see Optional Feature)
- pc_wb, ins_wb  out  32  forwarded to writeback
- trd_wb  out  3  thread
- reg_wr_wb  out  5  destination register
- wb_data_wb  out  32  writeback data
- wr_en_wb  out  1  writeback enable

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; timeout counter 0.
- FSM states IDLE and BUSY.
- IDLE, no access (mem_ctrl 00/11):
  - Next edge registers the pass-through: wb_data_wb = exe_data_mem, wr_en_wb = wr_en_mem & ~wb_sel_mem.
  - stall_mem = 0; latency 1.
- IDLE, access present:
  - dmem_req asserted combinationally the same cycle, with dmem_we = mem_ctrl[1], dmem_addr = {addr_mem[31:2], 2'b00}, dmem_wdata = exe_data_mem.
  - All stage inputs are captured into hold registers; upstream zeroes its registers on stall.
  - If dmem_ack is high the same cycle: complete (zero-wait).
  - Otherwise go to BUSY; stall_mem = 1 combinationally from this cycle.
- BUSY:
  - dmem_req is held high and request fields come from the hold registers, stable until ack.
  - Counter increments each cycle.
  - ack: register completion to WB, return to IDLE, stall_mem = 0 in the ack cycle.
  - Counter reaches TIMEOUT_CYC without ack: drop req, pulse mem_err, wr_en_wb = 0, return to IDLE.
- Completion:
  - Load: wb_data_wb = dmem_rdata, wr_en_wb = hold.wr_en.
  - Store: wr_en_wb = 0.
  - ack received in IDLE with no request is ignored.
- Thread control:
  - trd_ctrl != 00 pulses trd_cmd_en for exactly one cycle, registered, aligned with the WB output of that instruction.
  - Never pulsed twice across a stall.
- flushMEM:
  - In IDLE: next WB registers are zeroed (bubble), and no access or trd_cmd is issued.
  - In BUSY: ignored. A started access always completes, to keep the handshake legal.
- Reset mid-BUSY: dmem_req drops immediately (async); memory must tolerate an abandoned request.
- While stall_mem = 1, the WB registers hold a bubble (wr_en_wb = 0).
- Counter: 8-bit saturating width, sized as $clog2(TIMEOUT_CYC+1).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an access with addr_mem[1:0] != 0 issues no dmem_req, pulses mem_err, forces wr_en_wb = 0, and takes 1 cycle.
- Undefined: low address bits are silently truncated and the access proceeds.

Decomposition:
- Shared package: mem_ctrl encodings (MEM_NONE, MEM_LD, MEM_ST), trd_ctrl encodings (TRD_NONE, TRD_KILL, TRD_SLEEP, TRD_WAKE), and the FSM state enum.
- Sub-module dmem_if_fsm owns the handshake, hold registers and timeout counter.
- The top-level handles WB registers and thread commands.

Test Plan:
- ALU pass-through: mem_ctrl = 00, exe_data = 32'h1234, wr_en = 1, reg = 5 -> next cycle wb_data_wb = 32'h1234, wr_en_wb = 1, reg_wr_wb = 5, no dmem_req.
- Load, 3-cycle ack latency: addr = 32'h100, dmem_rdata = 32'hDEADBEEF on ack -> stall_mem high 3 cycles, dmem_addr stable at 32'h100, then wb_data_wb = 32'hDEADBEEF, wr_en_wb = 1.
- Store, zero-wait ack: addr = 32'h204, data = 32'hA5A5 -> dmem_we = 1 for one cycle, stall_mem never high, wr_en_wb = 0.
- Timeout: load, ack never arrives, TIMEOUT_CYC = 4 -> req high 4 cycles after entry, mem_err pulse, wr_en_wb = 0, FSM returns to IDLE.
- Thread kill during stalled load: trd_ctrl = 01, obj = 3 -> exactly one trd_cmd_en pulse with trd_cmd_id = 3.
- Async rst asserted mid-BUSY -> dmem_req and stall_mem go to 0 immediately; after release, a new load completes normally.
